spi_cmd_queue: RTL and testbench

Request queue and sequencer placed directly upstream of the SPI master. It accepts read and write requests from a valid/ready client and buffers them in a small FIFO. It issues one request at a time on the master's CMD/ADDR/WR_DATA interface, waits for WR_DONE or RD_DONE, and returns a per-transaction response with the read data. It replaces hand-driven CMD sequencing with back-to-back queued traffic plus a guard gap and a timeout.

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_cmd_queue_if.sv | 42 ++++
 rtl/spi_req_fifo.sv | 54 +++++
 rtl/spi_cmd_queue.sv | 123 ++++++++++++
 tb/tb_spi_cmd_queue.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command queue: master command codes,
// sequencer state encoding and the queued request entry.
package spi_pkg;

    localparam int PKG_DATA_BIT = 4;
    localparam int PKG_ADDR_BIT = 3;

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic                    rw;
        logic [PKG_ADDR_BIT-1:0] addr;
        logic [PKG_DATA_BIT-1:0] data;
    } req_entry_t;

    function automatic logic [1:0] cmd_for(input logic rw);
        return rw ? CMD_WRITE : CMD_READ;
    endfunction

endpackage

// File: rtl/spi_cmd_queue_if.sv
// Client request/response, SPI master command and status signals of the queue.
// The slave modport is the queue itself; master is whoever drives it.
interface spi_cmd_queue_if #(
    parameter int DATA_BIT   = 4,
    parameter int ADDR_BIT   = 3,
    parameter int DEPTH_LOG2 = 2
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_rw;
    logic [ADDR_BIT-1:0]   req_addr;
    logic [DATA_BIT-1:0]   req_data;

    logic [1:0]            cmd;
    logic [ADDR_BIT-1:0]   addr;
    logic [DATA_BIT-1:0]   wr_data;
    logic [DATA_BIT-1:0]   rd_data;
    logic                  wr_done;
    logic                  rd_done;

    logic                  rsp_valid;
    logic                  rsp_rw;
    logic [ADDR_BIT-1:0]   rsp_addr;
    logic [DATA_BIT-1:0]   rsp_data;
    logic                  rsp_err;

    logic                  busy;
    logic [DEPTH_LOG2:0]   level;

    modport slave (
        input  req_valid, req_rw, req_addr, req_data, rd_data, wr_done, rd_done,
        output req_ready, cmd, addr, wr_data, rsp_valid, rsp_rw, rsp_addr,
               rsp_data, rsp_err, busy, level
    );

    modport master (
        output req_valid, req_rw, req_addr, req_data, rd_data, wr_done, rd_done,
        input  req_ready, cmd, addr, wr_data, rsp_valid, rsp_rw, rsp_addr,
               rsp_data, rsp_err, busy, level
    );

endinterface

// File: rtl/spi_req_fifo.sv
// Synchronous first-word-fall-through FIFO of request entries; dout shows the
// head whenever the FIFO is not empty.
module spi_req_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  req_entry_t          din,
    output req_entry_t          dout,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    req_entry_t            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic                  do_push;
    logic                  do_pop;

    // Full blocks a push even when a pop happens on the same edge.
    assign full    = (level == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/spi_cmd_queue.sv
// Queues client read/write requests and sequences them one at a time onto the
// SPI master, with a done-or-timeout wait and a fixed idle gap between commands.
module spi_cmd_queue
    import spi_pkg::*;
#(
    parameter int DATA_BIT    = PKG_DATA_BIT,
    parameter int ADDR_BIT    = PKG_ADDR_BIT,
    parameter int DEPTH_LOG2  = 2,
    parameter int GAP_CYC     = 50,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_cmd_queue_if.slave bus
);

    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

    state_t              state;
    logic [1:0]          cmd_q;
    logic [ADDR_BIT-1:0] addr_q;
    logic [DATA_BIT-1:0] wdata_q;
    logic                rsp_valid_q;
    logic                rsp_rw_q;
    logic [ADDR_BIT-1:0] rsp_addr_q;
    logic [DATA_BIT-1:0] rsp_data_q;
    logic                rsp_err_q;
    logic [TO_W-1:0]     to_cnt;
    logic [GAP_W-1:0]    gap_cnt;

    req_entry_t          entry_in;
    req_entry_t          head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [DEPTH_LOG2:0] fifo_level;
    logic                pop;
    logic                wr_hit;
    logic                rd_hit;

    assign entry_in = '{rw: bus.req_rw, addr: bus.req_addr, data: bus.req_data};
    assign pop      = (state == S_IDLE) && !fifo_empty;

    spi_req_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.req_valid),
        .pop   (pop),
        .din   (entry_in),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // A done of the other type than the issued command is not a completion.
    assign wr_hit = (cmd_q == CMD_WRITE) && bus.wr_done;
    assign rd_hit = (cmd_q == CMD_READ)  && bus.rd_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cmd_q       <= CMD_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rw_q    <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            to_cnt      <= '0;
            gap_cnt     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        cmd_q   <= cmd_for(head.rw);
                        addr_q  <= head.addr;
                        wdata_q <= head.rw ? head.data : '0;
                        to_cnt  <= '0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Completion is checked first so it wins over a coincident timeout.
                    if (wr_hit || rd_hit || (to_cnt == TO_LAST)) begin
                        cmd_q       <= CMD_IDLE;
                        rsp_valid_q <= 1'b1;
                        rsp_rw_q    <= (cmd_q == CMD_WRITE);
                        rsp_addr_q  <= addr_q;
                        rsp_data_q  <= rd_hit ? bus.rd_data : '0;
                        rsp_err_q   <= !(wr_hit || rd_hit);
                        gap_cnt     <= GAP_LOAD;
                        state       <= S_GAP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) state <= S_IDLE;
                    else               gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = !fifo_full;
    assign bus.cmd       = cmd_q;
    assign bus.addr      = addr_q;
    assign bus.wr_data   = wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rw    = rsp_rw_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (state != S_IDLE) || !fifo_empty;
    assign bus.level     = fifo_level;

endmodule

// File: tb/tb_spi_cmd_queue.sv
// Bench for spi_cmd_queue: a responding SPI master model, an in-order
// scoreboard of issued commands and responses, directed corner cases and random traffic.
module tb_spi_cmd_queue;
    import spi_pkg::*;

    localparam int GAP = 50;
    localparam int TMO = 1023;

    typedef struct { bit rw; bit [2:0] addr; bit [3:0] data; bit err; } req_t;
    typedef struct { bit rw; bit [2:0] addr; bit [3:0] data; bit err; bit [3:0] wdata; } rsp_t;
    typedef struct { bit rw; bit [2:0] addr; bit [3:0] data; bit [3:0] exp_data; } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_cmd_queue_if #(.DATA_BIT(4), .ADDR_BIT(3), .DEPTH_LOG2(2)) bus ();

    spi_cmd_queue #(
        .DATA_BIT(4), .ADDR_BIT(3), .DEPTH_LOG2(2), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    req_t exp_issue[$];
    rsp_t exp_rsp[$];
    rsp_t obs_q[$];
    bit [3:0] model_mem [8];
    bit [3:0] slave_mem [8];

    int cyc = 0;
    int t_issue = -1000000;
    int t_rsp = -1000000;
    int last_gap = 0;

    bit master_en = 1'b1;
    bit master_rand = 1'b0;
    bit wrong_first = 1'b0;
    int master_delay = 5;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // SPI master model: answers each command after a delay, optionally with a wrong-type done first.
    initial begin
        int cnt = 0;
        int dly = 1;
        bit act = 1'b0;
        bit resp = 1'b0;
        bit wrong = 1'b0;
        bus.wr_done = 1'b0;
        bus.rd_done = 1'b0;
        bus.rd_data = '0;
        forever begin
            @(posedge clk); #1;
            bus.wr_done = 1'b0;
            bus.rd_done = 1'b0;
            if (bus.cmd == CMD_IDLE) begin
                act = 1'b0;
            end else if (!act) begin
                act = 1'b1;
                cnt = 0;
                resp = master_en;
                dly = master_rand ? int'($urandom_range(1, 40)) : master_delay;
                wrong = master_rand ? 1'($urandom_range(0, 1)) : wrong_first;
            end else begin
                cnt++;
            end
            if (act && resp) begin
                if (wrong && cnt == dly / 2) begin
                    if (bus.cmd == CMD_WRITE) bus.rd_done = 1'b1;
                    else                      bus.wr_done = 1'b1;
                end
                if (cnt == dly) begin
                    if (bus.cmd == CMD_WRITE) begin
                        slave_mem[bus.addr] = bus.wr_data;
                        bus.wr_done = 1'b1;
                    end else begin
                        bus.rd_data = slave_mem[bus.addr];
                        bus.rd_done = 1'b1;
                    end
                end
            end
        end
    end

    // Scoreboard: issue order, command hold, gap spacing and response contents.
    initial begin
        logic [1:0] cprev = CMD_IDLE;
        bit vprev = 1'b0;
        bit have_cur = 1'b0;
        req_t cur;
        rsp_t o;
        rsp_t e;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (!rst_n) begin
                cprev = CMD_IDLE;
                vprev = 1'b0;
                have_cur = 1'b0;
                t_rsp = -1000000;
                continue;
            end
            if (bus.cmd != CMD_IDLE && cprev == CMD_IDLE) begin
                if (exp_issue.size() == 0) begin
                    check("unexpected_issue", bus.cmd, CMD_IDLE);
                end else begin
                    cur = exp_issue.pop_front();
                    have_cur = 1'b1;
                    last_gap = cyc - t_rsp;
                    t_issue = cyc;
                    check("issue_gap_min", last_gap >= GAP + 1, 1);
                    check("issue_cmd", bus.cmd, cur.rw ? CMD_WRITE : CMD_READ);
                    check("issue_addr", bus.addr, cur.addr);
                    if (cur.rw) check("issue_wdata", bus.wr_data, cur.data);
                    exp_rsp.push_back('{rw: cur.rw, addr: cur.addr,
                                        data: (cur.rw || cur.err) ? 4'h0 : model_mem[cur.addr],
                                        err: cur.err, wdata: cur.data});
                end
            end else if (bus.cmd != CMD_IDLE && have_cur) begin
                check("hold_cmd", bus.cmd, cur.rw ? CMD_WRITE : CMD_READ);
                check("hold_addr", bus.addr, cur.addr);
            end
            if (bus.rsp_valid) begin
                o = '{rw: bus.rsp_rw, addr: bus.rsp_addr, data: bus.rsp_data, err: bus.rsp_err, wdata: 4'h0};
                t_rsp = cyc;
                obs_q.push_back(o);
                check("rsp_one_cycle", vprev, 0);
                check("rsp_cmd_idle", bus.cmd, CMD_IDLE);
                if (exp_rsp.size() == 0) begin
                    check("unexpected_rsp", bus.rsp_valid, 0);
                end else begin
                    e = exp_rsp.pop_front();
                    check("rsp_rw", o.rw, e.rw);
                    check("rsp_addr", o.addr, e.addr);
                    check("rsp_data", o.data, e.data);
                    check("rsp_err", o.err, e.err);
                    if (e.rw && !e.err) model_mem[e.addr] = e.wdata;
                end
                have_cur = 1'b0;
            end
            cprev = bus.cmd;
            vprev = bus.rsp_valid;
        end
    end

    task automatic push_req(input bit rw, input bit [2:0] a, input bit [3:0] d, input bit err);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_rw = rw;
        bus.req_addr = a;
        bus.req_data = d;
        while (!bus.req_ready && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.req_ready) check("push_accept", bus.req_ready, 1);
        else exp_issue.push_back('{rw: rw, addr: a, data: d, err: err});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output rsp_t r, input int budget);
        int n = 0;
        while (obs_q.size() == 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (obs_q.size() == 0) begin
            check("rsp_arrival", obs_q.size(), 1);
            r = '{default: 0};
        end else begin
            r = obs_q.pop_front();
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_issue.size() != 0 || exp_rsp.size() != 0 || bus.busy) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_busy", bus.busy, 0);
        check("drain_pending", exp_issue.size() + exp_rsp.size(), 0);
        obs_q.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[16];
        rsp_t r;
        int viol;
        int n;
        bit rw_r;
        bit [2:0] a_r;
        bit [3:0] d_r;

        for (int i = 0; i < 8; i++) begin
            tbl[i]     = '{rw: 1'b1, addr: 3'(i), data: 4'(i), exp_data: 4'h0};
            tbl[8 + i] = '{rw: 1'b0, addr: 3'(i), data: 4'h0, exp_data: 4'(i)};
        end

        bus.req_valid = 1'b0;
        bus.req_rw = 1'b0;
        bus.req_addr = '0;
        bus.req_data = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd", bus.cmd, CMD_IDLE);
        check("rst_addr", bus.addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_level", bus.level, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", bus.req_ready, 1);

        // Single write: latency, hold, response and gap
        master_delay = 20;
        bus.req_valid = 1'b1;
        bus.req_rw = 1'b1;
        bus.req_addr = 3'd3;
        bus.req_data = 4'h5;
        exp_issue.push_back('{rw: 1'b1, addr: 3'd3, data: 4'h5, err: 1'b0});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("lat_k_cmd", bus.cmd, CMD_IDLE);
        check("lat_k_level", bus.level, 1);
        @(posedge clk); #1;
        check("lat_k1_cmd", bus.cmd, CMD_WRITE);
        check("lat_k1_addr", bus.addr, 3);
        check("lat_k1_wdata", bus.wr_data, 5);
        check("lat_k1_busy", bus.busy, 1);
        wait_rsp(r, 200);
        check("w1_rw", r.rw, 1);
        check("w1_addr", r.addr, 3);
        check("w1_data", r.data, 0);
        check("w1_err", r.err, 0);
        check("w1_latency", t_rsp - t_issue, 21);
        viol = 0;
        for (int i = 0; i < GAP; i++) begin
            @(posedge clk); #1;
            if (bus.cmd != CMD_IDLE) viol++;
        end
        check("w1_gap_idle", viol, 0);
        check("w1_busy_after_gap", bus.busy, 0);
        wait_drain(100);

        // Table: write 0..7 then read back 0..7
        master_delay = 3;
        for (int i = 0; i < 16; i++) push_req(tbl[i].rw, tbl[i].addr, tbl[i].data, 1'b0);
        for (int i = 0; i < 16; i++) begin
            wait_rsp(r, 2000);
            check($sformatf("tbl%0d_rw", i), r.rw, tbl[i].rw);
            check($sformatf("tbl%0d_addr", i), r.addr, tbl[i].addr);
            check($sformatf("tbl%0d_data", i), r.data, tbl[i].exp_data);
            check($sformatf("tbl%0d_err", i), r.err, 0);
        end
        wait_drain(500);

        // Full queue with a stalled master
        master_delay = 300;
        push_req(1'b0, 3'd1, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) push_req(1'b1, 3'(4 + i), 4'(9 + i), 1'b0);
        check("full_level", bus.level, 4);
        check("full_ready", bus.req_ready, 0);
        bus.req_valid = 1'b1;
        bus.req_rw = 1'b0;
        bus.req_addr = 3'd5;
        bus.req_data = 4'h0;
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.level != 3'd4 || bus.req_ready) viol++;
        end
        check("full_no_accept", viol, 0);
        master_delay = 5;
        push_req(1'b0, 3'd5, 4'h0, 1'b0);
        check("full_refill_level", bus.level, 4);
        wait_drain(2000);

        // Timeout on a read, then the queued write follows after the gap
        master_en = 1'b0;
        push_req(1'b0, 3'd2, 4'h0, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        master_en = 1'b1;
        push_req(1'b1, 3'd6, 4'hA, 1'b0);
        wait_rsp(r, 1200);
        check("to_rw", r.rw, 0);
        check("to_addr", r.addr, 2);
        check("to_data", r.data, 0);
        check("to_err", r.err, 1);
        check("to_latency", t_rsp - t_issue, TMO);
        wait_rsp(r, 200);
        check("to_next_rw", r.rw, 1);
        check("to_next_err", r.err, 0);
        check("to_next_gap", last_gap, GAP + 1);
        wait_drain(200);

        // Wrong-type done ignored during a read
        wrong_first = 1'b1;
        master_delay = 10;
        push_req(1'b0, 3'd6, 4'h0, 1'b0);
        wait_rsp(r, 300);
        check("wt_rw", r.rw, 0);
        check("wt_addr", r.addr, 6);
        check("wt_data", r.data, 4'hA);
        check("wt_err", r.err, 0);
        check("wt_latency", t_rsp - t_issue, 11);
        repeat (60) begin @(posedge clk); #1; end
        check("wt_single_rsp", obs_q.size(), 0);
        wrong_first = 1'b0;
        wait_drain(200);

        // Reset in WAIT with two entries queued
        master_delay = 300;
        push_req(1'b1, 3'd0, 4'hF, 1'b0);
        push_req(1'b0, 3'd0, 4'h0, 1'b0);
        push_req(1'b0, 3'd7, 4'h0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        check("mid_cmd", bus.cmd, CMD_WRITE);
        check("mid_level", bus.level, 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cmd", bus.cmd, CMD_IDLE);
        check("mid_rst_level", bus.level, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_rsp_valid", bus.rsp_valid, 0);
        exp_issue.delete();
        exp_rsp.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        check("mid_no_rsp", obs_q.size(), 0);
        master_delay = 4;
        push_req(1'b0, 3'd0, 4'h0, 1'b0);
        wait_rsp(r, 200);
        check("post_rst_rw", r.rw, 0);
        check("post_rst_data", r.data, 0);
        check("post_rst_err", r.err, 0);
        wait_drain(200);

        // Random traffic against the scoreboard
        master_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rw_r = 1'($urandom_range(0, 1));
            a_r  = 3'($urandom_range(0, 7));
            d_r  = 4'($urandom_range(0, 15));
            push_req(rw_r, a_r, d_r, 1'b0);
            n = int'($urandom_range(0, 30));
            repeat (n) begin @(posedge clk); #1; end
        end
        wait_drain(6000);
        master_rand = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
